// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm sequencing block.
package alarm_pkg;
  localparam int TIME_W   = 6;
  localparam int MAX_HOUR = 23;
  localparam int MAX_MIN  = 59;
  localparam int MAX_SEC  = 59;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } alarm_state_t;
endpackage

// File: rtl/alarm_sec_counter.sv
// Saturating seconds counter: clear/load/increment/decrement, with a flag at TERM_VAL.
module alarm_sec_counter #(
  parameter int W        = 6,
  parameter int MAX_VAL  = 59,
  parameter int TERM_VAL = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic         term
);
  localparam logic [W-1:0] MAX_V  = W'(MAX_VAL);
  localparam logic [W-1:0] TERM_V = W'(TERM_VAL);

  logic [W-1:0] cnt;

  // Holds at either bound instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt <= '0;
    else if (clr)                  cnt <= '0;
    else if (load)                 cnt <= load_val;
    else if (inc && cnt != MAX_V)  cnt <= cnt + 1'b1;
    else if (dec && cnt != '0)     cnt <= cnt - 1'b1;
  end

  assign term = (cnt == TERM_V);
endmodule

// File: rtl/alarm_controller.sv
// Alarm ring/snooze/stop sequencer with registered buzzer and status outputs.
// Optional ALARM_BEEP_EN: buzzer pulses 1 s on / 1 s off while ringing.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int SNOOZE_SEC       = 300,
  parameter int MAX_SNOOZE       = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              tick_1hz,
  input  logic                              alarm_en,
  input  logic [TIME_W-1:0]                 cur_hour,
  input  logic [TIME_W-1:0]                 cur_min,
  input  logic [TIME_W-1:0]                 cur_sec,
  input  logic [TIME_W-1:0]                 a_hour,
  input  logic [TIME_W-1:0]                 a_min,
  input  logic                              snooze_p,
  input  logic                              stop_p,
  output logic                              buzzer,
  output logic                              ringing,
  output logic                              snoozing,
  output logic                              missed,
  output logic [$clog2(MAX_SNOOZE+1)-1:0]   snooze_left
);
  localparam int RC_W = $clog2(RING_TIMEOUT_SEC);
  localparam int SC_W = $clog2(SNOOZE_SEC+1);
  localparam int SL_W = $clog2(MAX_SNOOZE+1);
  localparam logic [SL_W-1:0] SL_MAX  = SL_W'(MAX_SNOOZE);
  localparam logic [SC_W-1:0] SNZ_LD  = SC_W'(SNOOZE_SEC);

  alarm_state_t state, state_nx;
  logic match, match_q, trig;
  logic ring_term, snz_term;
  logic new_event, ring_start, snz_start, ring_adv, ring_to, snz_adv;
  logic ring_nx;

  assign match = (cur_hour == a_hour) && (cur_min == a_min) && (cur_sec == '0);
  assign trig  = match && !match_q;

  // Event decode; alarm_en low overrides everything.
  always_comb begin
    state_nx   = state;
    new_event  = 1'b0;
    ring_start = 1'b0;
    snz_start  = 1'b0;
    ring_adv   = 1'b0;
    ring_to    = 1'b0;
    snz_adv    = 1'b0;
    if (!alarm_en) begin
      state_nx = ST_OFF;
    end else begin
      case (state)
        ST_OFF: state_nx = ST_ARMED;
        ST_ARMED: if (trig) begin
          new_event  = 1'b1;
          ring_start = 1'b1;
          state_nx   = ST_RINGING;
        end
        ST_RINGING: begin
          if (stop_p) begin
            state_nx = ST_ARMED;
          end else if (snooze_p && snooze_left != '0) begin
            snz_start = 1'b1;
            state_nx  = ST_SNOOZE;
          end else if (tick_1hz) begin
            ring_adv = 1'b1;
            if (ring_term) begin
              ring_to  = 1'b1;
              state_nx = ST_ARMED;
            end
          end
        end
        ST_SNOOZE: begin
          if (stop_p) begin
            state_nx = ST_ARMED;
          end else if (tick_1hz) begin
            snz_adv = 1'b1;
            if (snz_term) begin
              ring_start = 1'b1;
              state_nx   = ST_RINGING;
            end
          end
        end
        default: state_nx = ST_OFF;
      endcase
    end
  end

  assign ring_nx = (state_nx == ST_RINGING);

  alarm_sec_counter #(
    .W(RC_W), .MAX_VAL(RING_TIMEOUT_SEC-1), .TERM_VAL(RING_TIMEOUT_SEC-1)
  ) u_ring_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (!alarm_en || ring_start),
    .load     (1'b0),
    .load_val ('0),
    .inc      (ring_adv),
    .dec      (1'b0),
    .term     (ring_term)
  );

  alarm_sec_counter #(
    .W(SC_W), .MAX_VAL(SNOOZE_SEC), .TERM_VAL(1)
  ) u_snz_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (!alarm_en),
    .load     (snz_start),
    .load_val (SNZ_LD),
    .inc      (1'b0),
    .dec      (snz_adv),
    .term     (snz_term)
  );

`ifdef ALARM_BEEP_EN
  logic beep_ph, beep_nx;

  // Phase restarts "on" at every ring entry and flips each second of ringing.
  always_comb begin
    beep_nx = beep_ph;
    if (!alarm_en)       beep_nx = 1'b0;
    else if (ring_start) beep_nx = 1'b1;
    else if (ring_adv)   beep_nx = ~beep_ph;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beep_ph <= 1'b0;
    else        beep_ph <= beep_nx;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_OFF;
      match_q     <= 1'b0;
      buzzer      <= 1'b0;
      ringing     <= 1'b0;
      snoozing    <= 1'b0;
      missed      <= 1'b0;
      snooze_left <= SL_MAX;
    end else begin
      state    <= state_nx;
      match_q  <= match;
      ringing  <= ring_nx;
      snoozing <= (state_nx == ST_SNOOZE);
`ifdef ALARM_BEEP_EN
      buzzer   <= ring_nx && beep_nx;
`else
      buzzer   <= ring_nx;
`endif
      if (!alarm_en) begin
        snooze_left <= SL_MAX;
        missed      <= 1'b0;
      end else begin
        if (new_event)      snooze_left <= SL_MAX;
        else if (snz_start) snooze_left <= snooze_left - 1'b1;
        if (ring_to)                missed <= 1'b1;
        else if (stop_p || trig)    missed <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench: constant vector table, directed corner sequences, and a random run
// compared every cycle against a seconds-based behavioural model.
module tb_alarm_controller;
  localparam int RT = 60;
  localparam int SS = 300;
  localparam int MS = 3;

  logic clk = 1'b0, rst_n = 1'b0, tick_1hz = 1'b0, alarm_en = 1'b0;
  logic snooze_p = 1'b0, stop_p = 1'b0;
  logic [5:0] cur_hour = '0, cur_min = '0, cur_sec = '0;
  logic [5:0] a_hour = 6'd7, a_min = 6'd30;
  logic buzzer, ringing, snoozing, missed;
  logic [1:0] snooze_left;

  alarm_controller #(.RING_TIMEOUT_SEC(RT), .SNOOZE_SEC(SS), .MAX_SNOOZE(MS)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .alarm_en(alarm_en),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .a_hour(a_hour), .a_min(a_min), .snooze_p(snooze_p), .stop_p(stop_p),
    .buzzer(buzzer), .ringing(ringing), .snoozing(snoozing),
    .missed(missed), .snooze_left(snooze_left)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: "live" means the switch was already on at the previous edge.
  bit m_live, m_ring, m_snz, m_missed, m_beep, m_prev_match;
  int m_rung, m_snz_secs, m_left;

  task automatic model_reset();
    m_live = 0; m_ring = 0; m_snz = 0; m_missed = 0; m_beep = 0;
    m_prev_match = 0; m_rung = 0; m_snz_secs = 0; m_left = MS;
  endtask

  task automatic model_step();
    bit match, trig;
    match = (cur_hour == a_hour) && (cur_min == a_min) && (cur_sec == 0);
    trig = match && !m_prev_match;
    m_prev_match = match;
    if (!alarm_en) begin
      m_live = 0; m_ring = 0; m_snz = 0; m_missed = 0; m_left = MS; m_beep = 0;
      return;
    end
    if (stop_p || trig) m_missed = 0;
    if (!m_live) begin
      m_live = 1;
    end else if (m_ring) begin
      if (stop_p) m_ring = 0;
      else if (snooze_p && m_left > 0) begin
        m_ring = 0; m_snz = 1; m_snz_secs = SS; m_left--;
      end else if (tick_1hz) begin
        m_rung++;
        m_beep = !m_beep;
        if (m_rung == RT) begin m_ring = 0; m_missed = 1; end
      end
    end else if (m_snz) begin
      if (stop_p) m_snz = 0;
      else if (tick_1hz) begin
        m_snz_secs--;
        if (m_snz_secs == 0) begin m_snz = 0; m_ring = 1; m_rung = 0; m_beep = 1; end
      end
    end else if (trig) begin
      m_ring = 1; m_rung = 0; m_left = MS; m_missed = 0; m_beep = 1;
    end
  endtask

  task automatic check_model();
    bit exp_buz;
`ifdef ALARM_BEEP_EN
    exp_buz = m_ring && m_beep;
`else
    exp_buz = m_ring;
`endif
    checks++;
    if (buzzer !== exp_buz || ringing !== m_ring || snoozing !== m_snz ||
        missed !== m_missed || int'(snooze_left) != m_left) begin
      errors++;
      $display("FAIL model t=%0t got buz=%b ring=%b snz=%b miss=%b left=%0d want buz=%b ring=%b snz=%b miss=%b left=%0d",
               $time, buzzer, ringing, snoozing, missed, snooze_left,
               exp_buz, m_ring, m_snz, m_missed, m_left);
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, got, want, $time);
    end
  endtask

  // One clock: model sees the inputs sampled at the edge; outputs checked 1 ns later.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_step();
    else       model_reset();
    #1;
    check_model();
    tick_1hz = 0; snooze_p = 0; stop_p = 0;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    cur_hour = 6'(h); cur_min = 6'(m); cur_sec = 6'(s);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1; step();
      step();
    end
  endtask

  task automatic trigger();
    set_time(7, 29, 59); step();
    set_time(7, 30, 0);  step();
    set_time(7, 30, 5);
  endtask

  typedef struct {
    bit en; int h; int m; int s; bit snz; bit stp;
    bit e_ring; bit e_snz; int e_left;
  } vec_t;
  vec_t tbl[9];

  initial begin
    tbl[0] = '{1, 7, 29, 58, 0, 0, 0, 0, 3};
    tbl[1] = '{1, 7, 29, 59, 0, 0, 0, 0, 3};
    tbl[2] = '{1, 7, 30,  0, 0, 0, 1, 0, 3};  // trig -> ringing next cycle
    tbl[3] = '{1, 7, 30,  0, 0, 0, 1, 0, 3};  // held match: no retrigger
    tbl[4] = '{1, 7, 30,  1, 1, 0, 0, 1, 2};
    tbl[5] = '{1, 7, 30,  1, 0, 1, 0, 0, 2};
    tbl[6] = '{0, 7, 30,  2, 0, 0, 0, 0, 3};
    tbl[7] = '{1, 7, 30,  0, 0, 0, 0, 0, 3};  // trig while still OFF is lost
    tbl[8] = '{1, 7, 30,  0, 0, 0, 0, 0, 3};

    model_reset();
    step(); step();
    chk("rst_buzzer", buzzer, 0);
    chk("rst_ringing", ringing, 0);
    chk("rst_snoozing", snoozing, 0);
    chk("rst_missed", missed, 0);
    chk("rst_left", snooze_left, MS);
    rst_n = 1;

    for (int i = 0; i < 9; i++) begin
      alarm_en = tbl[i].en; set_time(tbl[i].h, tbl[i].m, tbl[i].s);
      snooze_p = tbl[i].snz; stop_p = tbl[i].stp;
      step();
      chk($sformatf("vec%0d_ring", i), ringing, tbl[i].e_ring);
      chk($sformatf("vec%0d_buz", i), buzzer, tbl[i].e_ring);
      chk($sformatf("vec%0d_snz", i), snoozing, tbl[i].e_snz);
      chk($sformatf("vec%0d_left", i), snooze_left, tbl[i].e_left);
    end

    // Three full snoozes, then a fourth snooze is refused.
    trigger();
    chk("snz_ring0", ringing, 1);
    for (int k = 0; k < 3; k++) begin
      snooze_p = 1; step();
      chk("snz_enter", snoozing, 1);
      chk("snz_left", snooze_left, 2 - k);
      tick_n(SS - 1);
      chk("snz_hold", snoozing, 1);
      tick_n(1);
      chk("snz_reringing", ringing, 1);
    end
    snooze_p = 1; step();
    chk("snz4_ring", ringing, 1);
    chk("snz4_left", snooze_left, 0);
    stop_p = 1; step();
    chk("snz_stop", ringing, 0);

    // Ring timeout sets missed; stop clears it.
    trigger();
    tick_n(RT - 1);
    chk("to_still_ring", ringing, 1);
    tick_n(1);
    chk("to_ring", ringing, 0);
    chk("to_missed", missed, 1);
    stop_p = 1; step();
    chk("to_missed_clr", missed, 0);

    // Stop wins over snooze on the same cycle.
    trigger();
    snooze_p = 1; stop_p = 1; step();
    chk("both_ring", ringing, 0);
    chk("both_snz", snoozing, 0);
    chk("both_left", snooze_left, MS);

    // Disarm during snooze.
    trigger();
    snooze_p = 1; step();
    tick_n(5);
    alarm_en = 0; step();
    chk("dis_snz", snoozing, 0);
    chk("dis_left", snooze_left, MS);
    alarm_en = 1; step();

`ifdef ALARM_BEEP_EN
    trigger();
    chk("beep_0", buzzer, 1);
    tick_1hz = 1; step();
    chk("beep_1", buzzer, 0);
    tick_1hz = 1; step();
    chk("beep_2", buzzer, 1);
    stop_p = 1; step();
    chk("beep_stop", buzzer, 0);
`endif

    // Asynchronous reset mid-ring.
    trigger();
    tick_n(2);
    chk("ar_ring", ringing, 1);
    chk("ar_buz", buzzer, 1);
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("ar_buz_now", buzzer, 0);
    chk("ar_ring_now", ringing, 0);
    chk("ar_left_now", snooze_left, MS);
    step();
    rst_n = 1;
    step(); step();
    trigger();
    chk("ar_rearm", ringing, 1);
    stop_p = 1; step();

    // Random run against the model.
    for (int c = 0; c < 6000; c++) begin
      int sel;
      if (!alarm_en) begin
        if ($urandom_range(0, 9) == 0) alarm_en = 1;
      end else if ($urandom_range(0, 399) == 0) alarm_en = 0;
      if ($urandom_range(0, 19) == 0) begin
        sel = $urandom_range(0, 4);
        case (sel)
          0: set_time(7, 29, 59);
          1, 2: set_time(7, 30, 0);
          3: set_time(7, 30, 1);
          default: set_time(7, 31, 0);
        endcase
      end
      if ($urandom_range(0, 499) == 0) a_min = (a_min == 6'd30) ? 6'd31 : 6'd30;
      tick_1hz = 1'($urandom_range(0, 1));
      snooze_p = ($urandom_range(0, 79) == 0);
      stop_p   = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
